// File: rtl/tmds_encoder_multi.sv
// ============================================================================
// Module : tmds_encoder_multi
// Multi-channel TMDS 8b/10b encoder with optional HDMI preamble/guard insertion.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tmds_encoder_multi #(
    parameter int NUM_CH    = 3,
    parameter int HDMI_MODE = 0,
    parameter int PRE_LEN   = 8,
    parameter int GB_LEN    = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_CH*8-1:0]    data_in,
    input  logic [NUM_CH*2-1:0]    control_in,
    input  logic                   ve_in,
    output logic [NUM_CH*10-1:0]   tmds_out,
    output logic                   ve_out,
    output logic                   short_blank_out
);

    localparam int c_DEPTH = PRE_LEN + GB_LEN;
    localparam int c_CW    = $clog2(PRE_LEN + GB_LEN + 1);

    localparam logic [9:0] c_CTL00 = 10'b1101010100;
    localparam logic [9:0] c_CTL01 = 10'b0010101011;
    localparam logic [9:0] c_CTL10 = 10'b0101010100;
    localparam logic [9:0] c_CTL11 = 10'b1010101011;
    localparam logic [9:0] c_GB_02 = 10'b1011001100;
    localparam logic [9:0] c_GB_1  = 10'b0100110011;

    typedef enum logic [1:0] {
        ST_CTRL  = 2'd0,
        ST_PRE   = 2'd1,
        ST_GUARD = 2'd2,
        ST_VIDEO = 2'd3
    } state_t;

    function automatic logic [9:0] ctl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = c_CTL00;
            2'b01:   s = c_CTL01;
            2'b10:   s = c_CTL10;
            default: s = c_CTL11;
        endcase
        return s;
    endfunction

    // Returns {next disparity, symbol} for one video byte.
    function automatic logic [14:0] enc_video(input logic [7:0] d, input logic signed [4:0] cnt);
        logic [3:0]        n1d;
        logic [3:0]        n1q;
        logic [8:0]        q;
        logic              use_xnor;
        logic signed [4:0] diff;
        logic signed [4:0] nc;
        logic [9:0]        s;
        n1d = 4'd0;
        for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, d[i]};
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        n1q = 4'd0;
        for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, q[i]};
        diff = $signed({1'b0, n1q}) - $signed({1'b0, 4'd8 - n1q});
        if ((cnt == 5'sd0) || (n1q == 4'd4)) begin
            s  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            nc = q[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (n1q > 4'd4)) || ((cnt < 5'sd0) && (n1q < 4'd4))) begin
            s  = {1'b1, q[8], ~q[7:0]};
            nc = cnt + (q[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            s  = {1'b0, q[8], q[7:0]};
            nc = cnt - (q[8] ? 5'sd0 : 5'sd2) + diff;
        end
        return {nc, s};
    endfunction

    logic [NUM_CH*8-1:0]  r_dl_data [c_DEPTH];
    logic [NUM_CH*2-1:0]  r_dl_ctrl [c_DEPTH];
    logic [c_DEPTH-1:0]   r_dl_ve;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_dl_data[i] <= '0;
                r_dl_ctrl[i] <= '0;
            end
            r_dl_ve <= '0;
        end else begin
            r_dl_data[0] <= data_in;
            r_dl_ctrl[0] <= control_in;
            r_dl_ve[0]   <= ve_in;
            for (int i = 1; i < c_DEPTH; i++) begin
                r_dl_data[i] <= r_dl_data[i-1];
                r_dl_ctrl[i] <= r_dl_ctrl[i-1];
                r_dl_ve[i]   <= r_dl_ve[i-1];
            end
        end
    end

    logic                w_dve;
    logic [NUM_CH*2-1:0] w_dctl;
    logic [NUM_CH*8-1:0] w_ddat;

    assign w_dve  = r_dl_ve[c_DEPTH-1];
    assign w_dctl = r_dl_ctrl[c_DEPTH-1];
    assign w_ddat = r_dl_data[c_DEPTH-1];

    state_t            r_state;
    logic [c_CW-1:0]   r_idx;
    logic              r_ve_prev;
    logic              r_dve_prev;
    logic              r_ve;
    logic              r_sb;

    logic              w_rise;
    logic              w_dfall;
    logic              w_idle;
    logic              w_accept;
    logic              w_short;
    state_t            w_st;
    logic [c_CW-1:0]   w_idx;
    state_t            w_st_nx;
    logic [c_CW-1:0]   w_idx_nx;

    // The preamble must start on the very cycle the undelayed edge is seen,
    // so the state used for encoding is resolved combinationally from r_state.
    always_comb begin
        w_rise   = ve_in & ~r_ve_prev;
        w_dfall  = r_dve_prev & ~w_dve;
        w_idle   = (r_state == ST_CTRL) || ((r_state == ST_VIDEO) && !w_dve);
        w_accept = (HDMI_MODE != 0) && w_rise && w_idle;
        w_short  = (HDMI_MODE != 0) && w_rise && !w_idle;
        w_st     = r_state;
        w_idx    = r_idx;
        if (w_accept) begin
            w_st  = ST_PRE;
            w_idx = '0;
        end else begin
            case (r_state)
                ST_VIDEO:          if (!w_dve)  w_st = ST_CTRL;
                ST_PRE, ST_GUARD:  if (w_dfall) w_st = ST_CTRL;
                default: ;
            endcase
        end
        w_st_nx  = w_st;
        w_idx_nx = w_idx + 1'b1;
        case (w_st)
            ST_PRE: begin
                if (w_idx == c_CW'(PRE_LEN - 1)) begin
                    w_st_nx  = ST_GUARD;
                    w_idx_nx = '0;
                end
            end
            ST_GUARD: begin
                if (w_idx == c_CW'(GB_LEN - 1)) begin
                    w_st_nx  = ST_VIDEO;
                    w_idx_nx = '0;
                end
            end
            default: w_idx_nx = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_CTRL;
            r_idx      <= '0;
            r_ve_prev  <= 1'b0;
            r_dve_prev <= 1'b0;
            r_ve       <= 1'b0;
            r_sb       <= 1'b0;
        end else begin
            r_state    <= w_st_nx;
            r_idx      <= w_idx_nx;
            r_ve_prev  <= ve_in;
            r_dve_prev <= w_dve;
            r_ve       <= w_dve;
            r_sb       <= w_short;
        end
    end

    assign ve_out          = r_ve;
    assign short_blank_out = r_sb;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [9:0]        r_sym;
        logic signed [4:0] r_disp;
        logic [1:0]        w_ctl;
        logic [14:0]       w_vid;
        logic [9:0]        w_sym;
        logic signed [4:0] w_disp_nx;

        always_comb begin
            w_ctl = w_dctl[2*c +: 2];
            if (w_st == ST_PRE) begin
                if (c == 1)      w_ctl = 2'b01;
                else if (c == 2) w_ctl = 2'b00;
            end
            w_vid = enc_video(w_ddat[8*c +: 8], r_disp);
            if (w_st == ST_GUARD) begin
                w_sym     = (c == 1) ? c_GB_1 : c_GB_02;
                w_disp_nx = 5'sd0;
            end else if ((w_st != ST_PRE) && w_dve) begin
                w_sym     = w_vid[9:0];
                w_disp_nx = w_vid[14:10];
            end else begin
                w_sym     = ctl_code(w_ctl);
                w_disp_nx = 5'sd0;
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_sym  <= '0;
                r_disp <= 5'sd0;
            end else begin
                r_sym  <= w_sym;
                r_disp <= w_disp_nx;
            end
        end

        assign tmds_out[10*c +: 10] = r_sym;
    end

endmodule

`default_nettype wire

// File: tb/tb_tmds_encoder_multi.sv
// ============================================================================
// Module : tb_tmds_encoder_multi
// Scoreboard bench driving a DVI and an HDMI instance with shared stimulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tmds_encoder_multi;

    localparam int NCH = 3;
    localparam int PRE = 8;
    localparam int GB  = 2;
    localparam int D   = PRE + GB;
    localparam int L   = D + 1;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] G02 = 10'b1011001100;
    localparam logic [9:0] G1  = 10'b0100110011;

    logic              clk;
    logic              rst;
    logic [NCH*8-1:0]  data_in;
    logic [NCH*2-1:0]  ctrl_in;
    logic              ve_in;
    logic [NCH*10-1:0] dvi_tmds;
    logic              dvi_ve;
    logic              dvi_sb;
    logic [NCH*10-1:0] h_tmds;
    logic              h_ve;
    logic              h_sb;

    tmds_encoder_multi #(.NUM_CH(NCH), .HDMI_MODE(0), .PRE_LEN(PRE), .GB_LEN(GB)) u_dvi (
        .clk_in(clk), .rst_in(rst), .data_in(data_in), .control_in(ctrl_in), .ve_in(ve_in),
        .tmds_out(dvi_tmds), .ve_out(dvi_ve), .short_blank_out(dvi_sb)
    );

    tmds_encoder_multi #(.NUM_CH(NCH), .HDMI_MODE(1), .PRE_LEN(PRE), .GB_LEN(GB)) u_hdmi (
        .clk_in(clk), .rst_in(rst), .data_in(data_in), .control_in(ctrl_in), .ve_in(ve_in),
        .tmds_out(h_tmds), .ve_out(h_ve), .short_blank_out(h_sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH*10-1:0] dsym;
        logic [NCH*10-1:0] hsym;
        logic              ve;
        logic [NCH*8-1:0]  data;
        logic              chk_h;
    } ent_t;

    ent_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         mcnt[NCH];
    int         obs[NCH];
    logic       prev_v;
    int         sb_seen, pre_seen, gb_seen;
    logic [9:0] rec_sym[$];
    int         rec_cnt[$];

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return C10;
            default: return C11;
        endcase
    endfunction

    function automatic logic [9:0] model_enc(input logic [7:0] d, input int cin, output int cout);
        int n1d, n1, n0;
        logic xn;
        logic [8:0] qm;
        logic [9:0] s;
        n1d = $countones(d);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (cin == 0 || n1 == n0) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cout = cin + (qm[8] ? (n1 - n0) : (n0 - n1));
        end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cout = cin - (qm[8] ? 0 : 2) + n1 - n0;
        end
        return s;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] qv;
        logic [7:0] d;
        qv = s[9] ? ~s[7:0] : s[7:0];
        d[0] = qv[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (qv[i] ^ qv[i-1]) : ~(qv[i] ^ qv[i-1]);
        return d;
    endfunction

    // One pixel cycle: push model expectation, drive, then score the output that is due.
    task automatic step(input logic [NCH*8-1:0] d, input logic [NCH*2-1:0] c, input logic v, input logic chk_h);
        ent_t e;
        ent_t t;
        int   nc;
        logic quiet;
        logic bad;
        e.ve = v; e.data = d; e.chk_h = chk_h;
        for (int ch = 0; ch < NCH; ch++) begin
            if (v) begin
                e.dsym[10*ch +: 10] = model_enc(d[8*ch +: 8], mcnt[ch], nc);
                mcnt[ch] = nc;
            end else begin
                e.dsym[10*ch +: 10] = ctl_sym(c[2*ch +: 2]);
                mcnt[ch] = 0;
            end
        end
        e.hsym = e.dsym;
        quiet = 1'b1;
        foreach (q[i]) if (q[i].ve) quiet = 1'b0;
        if (v && !prev_v && quiet) begin
            for (int i = 0; i < q.size(); i++) begin
                t = q[i];
                if (i < PRE) begin
                    t.hsym[19:10] = C01;
                    t.hsym[29:20] = C00;
                end else begin
                    t.hsym[9:0] = G02; t.hsym[19:10] = G1; t.hsym[29:20] = G02;
                end
                q[i] = t;
            end
        end
        prev_v = v;
        q.push_back(e);
        data_in = d; ctrl_in = c; ve_in = v;
        @(negedge clk);
        if (h_sb) sb_seen++;
        if (!h_ve && h_tmds[19:10] == C01) pre_seen++;
        if (!h_ve && h_tmds[19:10] == G1)  gb_seen++;
        for (int ch = 0; ch < NCH; ch++) begin
            if (dvi_ve) obs[ch] += 2 * $countones(dvi_tmds[10*ch +: 10]) - 10;
            else        obs[ch] = 0;
        end
        if (dvi_ve) begin
            rec_sym.push_back(dvi_tmds[9:0]);
            rec_cnt.push_back(obs[0]);
        end
        if (q.size() >= L) begin
            e = q.pop_front();
            n_tests++;
            if (dvi_tmds !== e.dsym || dvi_ve !== e.ve) begin
                n_fail++;
                $display("FAIL dvi_sym got=%h/%b exp=%h/%b", dvi_tmds, dvi_ve, e.dsym, e.ve);
            end
            if (e.chk_h) begin
                n_tests++;
                if (h_tmds !== e.hsym || h_ve !== e.ve) begin
                    n_fail++;
                    $display("FAIL hdmi_sym got=%h/%b exp=%h/%b", h_tmds, h_ve, e.hsym, e.ve);
                end
            end
            if (e.ve) begin
                bad = 1'b0;
                for (int ch = 0; ch < NCH; ch++) if (decode(dvi_tmds[10*ch +: 10]) !== e.data[8*ch +: 8]) bad = 1'b1;
                n_tests++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL decode got=%h exp_bytes=%h", dvi_tmds, e.data);
                end
                bad = 1'b0;
                for (int ch = 0; ch < NCH; ch++) if (obs[ch] > 8 || obs[ch] < -8) bad = 1'b1;
                n_tests++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL disparity_bound got=%0d,%0d,%0d limit=8", obs[0], obs[1], obs[2]);
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; data_in = '0; ctrl_in = '0; ve_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_tests++;
            if (dvi_tmds !== '0 || dvi_ve !== 1'b0 || h_tmds !== '0 || h_ve !== 1'b0 || h_sb !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs got dvi=%h/%b hdmi=%h/%b sb=%b exp=0", dvi_tmds, dvi_ve, h_tmds, h_ve, h_sb);
            end
        end
        rst = 1'b0;
        q.delete();
        for (int i = 0; i < D; i++) q.push_back('{dsym: {C00, C00, C00}, hsym: {C00, C00, C00}, ve: 1'b0, data: '0, chk_h: 1'b1});
        for (int ch = 0; ch < NCH; ch++) begin mcnt[ch] = 0; obs[ch] = 0; end
        prev_v = 1'b0; sb_seen = 0; pre_seen = 0; gb_seen = 0;
        rec_sym.delete(); rec_cnt.delete();
    endtask

    task automatic test_reset();
        do_reset(3);
        for (int i = 0; i < L + 4; i++) step('0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_dvi_control();
        for (int i = 0; i < 20; i++) begin
            step('0, 6'b000011, 1'b0, 1'b0);
            if (i == L + 2) begin
                n_tests++;
                if (dvi_tmds[9:0] !== C11 || dvi_tmds[19:10] !== C00 || dvi_tmds[29:20] !== C00) begin
                    n_fail++;
                    $display("FAIL dvi_ctrl11 got=%h exp=%h", dvi_tmds, {C00, C00, C11});
                end
            end
        end
        for (int i = 0; i < L; i++) step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_dvi_zeros();
        rec_sym.delete(); rec_cnt.delete();
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        for (int i = 0; i < L + 2; i++) step('0, '0, 1'b0, 1'b0);
        n_tests++;
        if (rec_sym.size() != 2) begin
            n_fail++;
            $display("FAIL zeros_count got=%0d exp=2", rec_sym.size());
        end else begin
            n_tests += 2;
            if (rec_sym[0] !== 10'b0100000000 || rec_cnt[0] != -8) begin
                n_fail++;
                $display("FAIL zeros_first got=%b cnt=%0d exp=0100000000 cnt=-8", rec_sym[0], rec_cnt[0]);
            end
            if (rec_sym[1] !== 10'b1111111111 || rec_cnt[1] != 2) begin
                n_fail++;
                $display("FAIL zeros_second got=%b cnt=%0d exp=1111111111 cnt=2", rec_sym[1], rec_cnt[1]);
            end
        end
    endtask

    task automatic test_dvi_random();
        for (int i = 0; i < 1000; i++) step(NCH*8'($urandom), '0, 1'b1, 1'b0);
        for (int i = 0; i < L + 2; i++) step('0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_hdmi_preamble();
        do_reset(2);
        for (int i = 0; i < 40; i++) step('0, 6'b000001, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step({3{8'h10}}, '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step('0, '0, 1'b0, 1'b1);
        n_tests += 3;
        if (pre_seen != PRE) begin n_fail++; $display("FAIL pre_cycles got=%0d exp=%0d", pre_seen, PRE); end
        if (gb_seen != GB)   begin n_fail++; $display("FAIL guard_cycles got=%0d exp=%0d", gb_seen, GB); end
        if (sb_seen != 0)    begin n_fail++; $display("FAIL short_blank_none got=%0d exp=0", sb_seen); end
    endtask

    task automatic test_hdmi_short_blank();
        do_reset(2);
        for (int i = 0; i < 20; i++) step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(NCH*8'($urandom), '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++)  step('0, 6'b000010, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(NCH*8'($urandom), '0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step('0, '0, 1'b0, 1'b1);
        n_tests += 3;
        if (sb_seen != 1)  begin n_fail++; $display("FAIL short_blank_pulse got=%0d exp=1", sb_seen); end
        if (gb_seen != GB) begin n_fail++; $display("FAIL short_guard got=%0d exp=%0d", gb_seen, GB); end
        if (pre_seen != PRE) begin n_fail++; $display("FAIL short_pre got=%0d exp=%0d", pre_seen, PRE); end
    endtask

    task automatic test_hdmi_reset_mid_pre();
        do_reset(2);
        for (int i = 0; i < 15; i++) step('0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)  step({3{8'h55}}, '0, 1'b1, 1'b1);
        do_reset(1);
        for (int i = 0; i < 15; i++) step('0, '0, 1'b0, 1'b1);
        n_tests++;
        if (pre_seen != 0) begin n_fail++; $display("FAIL post_reset_pre got=%0d exp=0", pre_seen); end
    endtask

    initial begin
        rst = 1'b1; data_in = '0; ctrl_in = '0; ve_in = 1'b0; prev_v = 1'b0;
        @(negedge clk);
        test_reset();
        test_dvi_control();
        test_dvi_zeros();
        test_dvi_random();
        test_hdmi_preamble();
        test_hdmi_short_blank();
        test_hdmi_reset_mid_pre();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
